// File: rtl/multdiv_sequencer_pkg.sv
// Shared state encoding and rstatus constants for the mul/div sequencer.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] RSTATUS_REG  = 5'd30;
    localparam logic [7:0] MUL_EXC_CODE = 8'd4;
    localparam logic [7:0] DIV_EXC_CODE = 8'd5;

    function automatic logic [7:0] exc_code(input logic is_div);
        return is_div ? DIV_EXC_CODE : MUL_EXC_CODE;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_timeout.sv
// Cycle counter that flags when the multdiv unit has been busy for LIMIT cycles.
module md_timeout_counter #(
    parameter int LIMIT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // Saturates on the last count so a stuck enable can never wrap around.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one mul/div through the shared iterative unit, stalling the pipeline
// and converting unit errors or timeouts into an rstatus write.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int DATA_W         = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              issue_is_div,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [4:0]        issue_rd,
    input  logic              flush,
    output logic              md_start_mult,
    output logic              md_start_div,
    output logic [DATA_W-1:0] md_a,
    output logic [DATA_W-1:0] md_b,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_ready,
    output logic              stall,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic [4:0]        result_rd,
    output logic              result_exception
);

    state_t     r_state;
    logic       r_is_div;
    logic [4:0] r_rd;

    logic w_accept;
    logic w_expired;
    logic w_finish;
    logic w_take_exc;

    md_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (r_state == START),
        .i_enable (r_state == BUSY),
        .o_expired(w_expired)
    );

    assign w_accept   = (r_state == IDLE) && issue_valid && !flush;
    assign w_finish   = !flush && (md_ready || w_expired);
    assign w_take_exc = md_ready ? md_exception : 1'b1;

    // Stall and start decode straight from state so they react to flush in the same cycle;
    // gating with reset keeps every output low while reset is held.
    always_comb begin
        stall         = 1'b0;
        md_start_mult = 1'b0;
        md_start_div  = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: stall = issue_valid && !flush;
                START: begin
                    stall         = !flush;
                    md_start_mult = !r_is_div && !flush;
                    md_start_div  = r_is_div && !flush;
                end
                BUSY:    stall = !flush;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_is_div         <= 1'b0;
            r_rd             <= '0;
            md_a             <= '0;
            md_b             <= '0;
            result_valid     <= 1'b0;
            result_data      <= '0;
            result_rd        <= '0;
            result_exception <= 1'b0;
        end else begin
            result_valid     <= 1'b0;
            result_data      <= '0;
            result_rd        <= '0;
            result_exception <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        md_a     <= issue_a;
                        md_b     <= issue_b;
                        r_is_div <= issue_is_div;
                        r_rd     <= issue_rd;
                        r_state  <= START;
                    end
                end
                START: begin
                    r_state <= flush ? IDLE : BUSY;
                end
                BUSY: begin
                    // A real md_ready takes priority over the timeout when both land together.
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (w_finish) begin
                        r_state          <= DONE;
                        result_valid     <= 1'b1;
                        result_exception <= w_take_exc;
                        result_rd        <= w_take_exc ? RSTATUS_REG : r_rd;
                        result_data      <= w_take_exc ? DATA_W'(exc_code(r_is_div)) : md_result;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer with a simple behavioural multdiv unit.
module tb_multdiv_sequencer;

    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 40;

    logic              clock;
    logic              reset;
    logic              issue_valid;
    logic              issue_is_div;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [4:0]        issue_rd;
    logic              flush;
    logic              md_start_mult;
    logic              md_start_div;
    logic [DATA_W-1:0] md_a;
    logic [DATA_W-1:0] md_b;
    logic [DATA_W-1:0] md_result;
    logic              md_exception;
    logic              md_ready;
    logic              stall;
    logic              result_valid;
    logic [DATA_W-1:0] result_data;
    logic [4:0]        result_rd;
    logic              result_exception;

    multdiv_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .DATA_W        (DATA_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_is_div    (issue_is_div),
        .issue_a         (issue_a),
        .issue_b         (issue_b),
        .issue_rd        (issue_rd),
        .flush           (flush),
        .md_start_mult   (md_start_mult),
        .md_start_div    (md_start_div),
        .md_a            (md_a),
        .md_b            (md_b),
        .md_result       (md_result),
        .md_exception    (md_exception),
        .md_ready        (md_ready),
        .stall           (stall),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_rd       (result_rd),
        .result_exception(result_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        exc;
    } exp_t;

    exp_t expQ[$];
    int total      = 0;
    int bad        = 0;
    int multStarts = 0;
    int divStarts  = 0;
    int stallCnt   = 0;
    int resultCnt  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts pulses and stall cycles; every result beat is matched against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (md_start_mult) multStarts++;
        if (md_start_div)  divStarts++;
        if (stall)         stallCnt++;
        if (result_valid) begin
            resultCnt++;
            checkOutput("done_stall", {31'd0, stall}, 32'd0);
            checkOutput("sb_nonempty", {31'd0, (expQ.size() > 0)}, 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("res_data", result_data, e.data);
                checkOutput("res_rd", {27'd0, result_rd}, {27'd0, e.rd});
                checkOutput("res_exc", {31'd0, result_exception}, {31'd0, e.exc});
            end
        end
    end

    // Issues one op and plays the unit: delay = BUSY cycle of md_ready, 0 = never answers.
    task automatic applyStimulus(input string tag, input logic isDiv,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input int delay, input logic exc,
                                 input logic stale, input logic flushDone, input int expStall);
        exp_t e;
        logic [31:0] res;
        int m0;
        int d0;
        int r0;
        res = isDiv ? ((b != 0) ? a / b : 32'hFFFF_FFFF) : a * b;
        if (exc || delay == 0) begin
            e.data = isDiv ? 32'd5 : 32'd4;
            e.rd   = 5'd30;
            e.exc  = 1'b1;
        end else begin
            e.data = res;
            e.rd   = rd;
            e.exc  = 1'b0;
        end
        expQ.push_back(e);
        m0 = multStarts;
        d0 = divStarts;
        r0 = resultCnt;
        stallCnt     = 0;
        issue_valid  = 1'b1;
        issue_is_div = isDiv;
        issue_a      = a;
        issue_b      = b;
        issue_rd     = rd;
        tick();
        if (stale) begin
            md_ready     = 1'b1;
            md_exception = 1'b1;
            md_result    = 32'hDEAD_BEEF;
        end
        @(negedge clock);
        checkOutput({tag, "_start"}, {31'd0, isDiv ? md_start_div : md_start_mult}, 32'd1);
        tick();
        md_ready     = 1'b0;
        md_exception = 1'b0;
        checkOutput({tag, "_md_a"}, md_a, a);
        checkOutput({tag, "_md_b"}, md_b, b);
        if (delay != 0) begin
            for (int i = 1; i < delay; i++) tick();
            md_ready     = 1'b1;
            md_result    = res;
            md_exception = exc;
            tick();
            md_ready     = 1'b0;
            md_exception = 1'b0;
            flush        = flushDone;
        end
        for (int i = 0; i < 60 && resultCnt == r0; i++) @(posedge clock);
        #1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        checkOutput({tag, "_beats"}, resultCnt - r0, 32'd1);
        checkOutput({tag, "_mult_starts"}, multStarts - m0, isDiv ? 32'd0 : 32'd1);
        checkOutput({tag, "_div_starts"}, divStarts - d0, isDiv ? 32'd1 : 32'd0);
        checkOutput({tag, "_stall_cycles"}, stallCnt, expStall);
    endtask

    initial begin
        int m0;
        int d0;
        int r0;
        reset        = 1'b0;
        issue_valid  = 1'b0;
        issue_is_div = 1'b0;
        issue_a      = '0;
        issue_b      = '0;
        issue_rd     = '0;
        flush        = 1'b0;
        md_result    = '0;
        md_exception = 1'b0;
        md_ready     = 1'b0;

        repeat (2) @(negedge clock);
        checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_start", {30'd0, md_start_mult, md_start_div}, 32'd0);
        checkOutput("rst_md_a", md_a, 32'd0);
        checkOutput("rst_data", result_data, 32'd0);
        checkOutput("rst_rd", {27'd0, result_rd}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();

        issue_valid = 1'b1;
        #1;
        checkOutput("idle_comb_stall", {31'd0, stall}, 32'd1);
        issue_valid = 1'b0;
        tick();

        applyStimulus("mul6x7", 1'b0, 32'd6, 32'd7, 5'd5, 16, 1'b0, 1'b0, 1'b0, 18);
        tick();
        applyStimulus("div_exc", 1'b1, 32'd100, 32'd0, 5'd7, 5, 1'b1, 1'b0, 1'b0, 7);
        tick();
        applyStimulus("mul_tmo", 1'b0, 32'd9, 32'd9, 5'd3, 0, 1'b0, 1'b0, 1'b0, 42);
        tick();
        applyStimulus("min_lat", 1'b0, 32'd3, 32'd5, 5'd9, 1, 1'b0, 1'b1, 1'b1, 3);
        tick();
        applyStimulus("tie_ready", 1'b1, 32'd1000, 32'd7, 5'd12, 40, 1'b0, 1'b0, 1'b0, 42);
        tick();

        // Flush in BUSY cycle 5, then a new op two cycles later.
        m0 = multStarts;
        r0 = resultCnt;
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_a      = 32'd2;
        issue_b      = 32'd3;
        issue_rd     = 5'd4;
        tick();
        tick();
        repeat (4) tick();
        flush       = 1'b1;
        issue_valid = 1'b0;
        #1;
        checkOutput("busy_flush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        tick();
        checkOutput("busy_flush_beats", resultCnt - r0, 32'd0);
        checkOutput("busy_flush_starts", multStarts - m0, 32'd1);
        applyStimulus("after_flush", 1'b1, 32'd50, 32'd5, 5'd6, 4, 1'b0, 1'b0, 1'b0, 6);
        tick();

        // Flush in START suppresses the pulse.
        m0 = multStarts;
        r0 = resultCnt;
        issue_valid = 1'b1;
        issue_is_div = 1'b0;
        tick();
        flush       = 1'b1;
        issue_valid = 1'b0;
        #1;
        checkOutput("start_flush_pulse", {31'd0, md_start_mult}, 32'd0);
        checkOutput("start_flush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        repeat (2) tick();
        checkOutput("start_flush_starts", multStarts - m0, 32'd0);
        checkOutput("start_flush_beats", resultCnt - r0, 32'd0);

        applyStimulus("b2b_mul", 1'b0, 32'd11, 32'd13, 5'd1, 3, 1'b0, 1'b0, 1'b0, 5);
        applyStimulus("b2b_div", 1'b1, 32'd99, 32'd9, 5'd2, 2, 1'b0, 1'b0, 1'b0, 4);
        tick();

        // Reset in BUSY aborts with every output forced low.
        m0 = multStarts;
        d0 = divStarts;
        r0 = resultCnt;
        issue_valid  = 1'b1;
        issue_is_div = 1'b0;
        issue_a      = 32'd8;
        issue_b      = 32'd8;
        issue_rd     = 5'd10;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        checkOutput("arst_stall", {31'd0, stall}, 32'd0);
        checkOutput("arst_md_a", md_a, 32'd0);
        checkOutput("arst_md_b", md_b, 32'd0);
        checkOutput("arst_valid", {31'd0, result_valid}, 32'd0);
        tick();
        issue_valid = 1'b0;
        reset       = 1'b1;
        repeat (5) tick();
        checkOutput("arst_beats", resultCnt - r0, 32'd0);
        checkOutput("arst_starts", multStarts - m0 + divStarts - d0, 32'd1);
        applyStimulus("post_rst", 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd31, 2, 1'b0, 1'b0, 1'b0, 4);
        repeat (3) tick();
        checkOutput("sb_drained", expQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Controls the shared iterative multiply/divide unit for the 5-stage pipeline.
- Accepts one mul/div issue from the execute stage and latches its operands.
- Drives a one-cycle start pulse, holds the pipeline stall until the unit finishes or times out, then presents one result beat for the X/M latch.
- Converts a unit exception or a timeout into an rstatus write: r30 = 4 for mul, r30 = 5 for div.

Parameters:
- TIMEOUT_CYCLES, 40, BUSY cycles allowed before a forced exception; must be ≥ 2.
- DATA_W, 32, operand and result width.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- issue_valid  in  1  execute-stage instruction is mul or div.
- issue_is_div  in  1  1 = div, 0 = mul; sampled with issue_valid.
- issue_a  in  DATA_W  bypassed operand A.
- issue_b  in  DATA_W  bypassed operand B.
- issue_rd  in  5  destination register.
- flush  in  1  branch/jump squash of the execute stage.
- md_start_mult  out  1  start pulse to the multdiv unit.
- md_start_div  out  1  start pulse to the multdiv unit.
- md_a  out  DATA_W  latched operand A, held stable from START until return to IDLE.
- md_b  out  DATA_W  latched operand B, same holding rule.
- md_result  in  DATA_W  unit result.
- md_exception  in  1  unit error, valid with md_ready.
- md_ready  in  1  unit done, one-cycle pulse.
- stall  out  1  freezes PC, F/D, D/X and X/M.
- result_valid  out  1  one-cycle result beat.
- result_data  out  DATA_W  result, or rstatus code on exception.
- result_rd  out  5  issue_rd, or 30 on exception.
- result_exception  out  1  result is an rstatus write.

Behaviour:
- States: IDLE, START, BUSY, DONE. Reset (reset low) forces IDLE, clears the counter and latches, and drives every output to 0.
- IDLE
  - On issue_valid & ~flush: latch issue_a, issue_b, issue_is_div and issue_rd, then go to START.
  - stall = issue_valid & ~flush, combinational, so the issuing instruction never advances.
- START
  - md_start_mult = ~is_div & ~flush; md_start_div = is_div & ~flush. Exactly one pulse per accepted issue.
  - md_ready in this cycle is ignored as stale.
  - Go to BUSY and clear the counter to 0. stall = 1.
- BUSY
  - stall = 1. Counter increments each cycle.
  - md_ready: capture md_result and md_exception, go to DONE.
  - Counter = TIMEOUT_CYCLES-1 with no md_ready: go to DONE with exception = 1.
  - If md_ready and timeout coincide, md_ready wins.
- DONE
  - result_valid = 1 and stall = 0, so the pipeline advances the instruction this cycle.
  - Normal result: result_data = captured result, result_rd = latched rd, result_exception = 0.
  - Exception: result_data = 4 (mul) or 5 (div), result_rd = 30, result_exception = 1.
  - issue_valid in DONE is ignored because it is the same instruction. Next state is IDLE.
  - A back-to-back mul/div is accepted on the following IDLE cycle.
- Flush
  - In START or BUSY: return to IDLE next cycle, no result_valid, stall drops in that flush cycle, start is suppressed in START.
  - In DONE: the result beat is still emitted.
- Outputs are registered except stall and md_start_*, which are decoded from state plus flush.
- Minimum issue-to-result latency is 3 cycles: IDLE, START, then md_ready in the first BUSY cycle, giving DONE.
- Reset asserted mid-operation aborts the operation with no result beat.

Decomposition:
- Shared package: state encoding (2 bits), RSTATUS_REG = 30, MUL_EXC_CODE = 4, DIV_EXC_CODE = 5.
- Optional sub-module md_timeout_counter: clear, enable, expired. Otherwise a single module.

Test Plan:
1. Mul of 6 × 7, md_ready 16 cycles after start:
   - exactly one md_start_mult pulse;
   - stall high for 18 cycles;
   - result_valid with result_data = 42, result_rd = issue_rd, stall low in the DONE cycle.
2. Div with md_exception = 1 on md_ready → result_rd = 30, result_data = 5, result_exception = 1.
3. md_ready never asserted, TIMEOUT_CYCLES = 40:
   - DONE entered after 40 BUSY cycles;
   - mul gives result_data = 4, result_rd = 30.
4. Flush asserted in cycle 5 of BUSY → no result_valid, stall low in the flush cycle, a new issue 2 cycles later starts cleanly.
5. Back-to-back mul then div:
   - issue_valid held through DONE does not re-trigger;
   - the second op's md_start_div fires once after IDLE.
6. reset pulled low in BUSY → all outputs 0 asynchronously, state IDLE, no stale result after release.
